// File: rtl/axis_packetizer_pkg.sv
// Shared types and helpers for axis_packetizer.
// The hold-state encoding is only used when AXIS_PACKETIZER_TIMEOUT_EN is defined.
package axis_packetizer_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HELD  = 1'b1
    } hold_state_e;

    // Bits needed to count 0..v-1; never less than one bit.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/axis_packetizer_reg.sv
// One-entry AXI-Stream register slice carrying an explicit tlast input.
// Loads whenever empty or when the downstream consumer takes the current beat.
module axis_packetizer_reg #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned KEEP_W     = 1,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DEST_WIDTH = 1
) (
    input  logic                  aclk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [KEEP_W-1:0]     in_keep,
    input  logic                  in_last,
    input  logic [USER_WIDTH-1:0] in_user,
    input  logic [DEST_WIDTH-1:0] in_dest,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [KEEP_W-1:0]     out_keep,
    output logic                  out_last,
    output logic [USER_WIDTH-1:0] out_user,
    output logic [DEST_WIDTH-1:0] out_dest
);

    logic                  valid_q;
    logic [DATA_W-1:0]     data_q;
    logic [KEEP_W-1:0]     keep_q;
    logic                  last_q;
    logic [USER_WIDTH-1:0] user_q;
    logic [DEST_WIDTH-1:0] dest_q;

    assign in_ready = !valid_q || out_ready;

    always_ff @(posedge aclk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            keep_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= '0;
            dest_q  <= '0;
        end else if (in_ready) begin
            valid_q <= in_valid;
            if (in_valid) begin
                data_q <= in_data;
                keep_q <= in_keep;
                last_q <= in_last;
                user_q <= in_user;
                dest_q <= in_dest;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_keep  = keep_q;
    assign out_last  = last_q;
    assign out_user  = user_q;
    assign out_dest  = dest_q;

endmodule

// File: rtl/axis_packetizer.sv
// Splits an AXI-Stream into packets of PACKET_SIZE beats, honouring upstream tlast.
// AXIS_PACKETIZER_TIMEOUT_EN adds a hold stage that flushes a packet after TIMEOUT idle cycles.
module axis_packetizer
    import axis_packetizer_pkg::*;
#(
    parameter int unsigned BUS_WIDTH   = 1,
    parameter int unsigned USER_WIDTH  = 1,
    parameter int unsigned DEST_WIDTH  = 1,
    parameter int unsigned PACKET_SIZE = 16,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                   aclk,
    input  logic                   rst,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [BUS_WIDTH*8-1:0] s_axis_tdata,
    input  logic [BUS_WIDTH-1:0]   s_axis_tkeep,
    input  logic                   s_axis_tlast,
    input  logic [USER_WIDTH-1:0]  s_axis_tuser,
    input  logic [DEST_WIDTH-1:0]  s_axis_tdest,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [BUS_WIDTH*8-1:0] m_axis_tdata,
    output logic [BUS_WIDTH-1:0]   m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic [USER_WIDTH-1:0]  m_axis_tuser,
    output logic [DEST_WIDTH-1:0]  m_axis_tdest,
    output logic [31:0]            packet_count
);

    localparam int unsigned CNT_W = clog2(PACKET_SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PACKET_SIZE - 1);

    if (PACKET_SIZE < 1 || PACKET_SIZE > 65535 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
        $error("axis_packetizer: PACKET_SIZE or TIMEOUT out of range");
    end

    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic                   reg_valid, reg_ready, reg_last;
    logic [BUS_WIDTH*8-1:0] reg_data;
    logic [BUS_WIDTH-1:0]   reg_keep;
    logic [USER_WIDTH-1:0]  reg_user;
    logic [DEST_WIDTH-1:0]  reg_dest;
    logic                   accept, is_last;

`ifdef AXIS_PACKETIZER_TIMEOUT_EN
    localparam int unsigned TMO_W = clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT - 1);

    hold_state_e            hold_q, hold_d;
    logic [BUS_WIDTH*8-1:0] hold_data_q;
    logic [BUS_WIDTH-1:0]   hold_keep_q;
    logic                   hold_last_q;
    logic [USER_WIDTH-1:0]  hold_user_q;
    logic [DEST_WIDTH-1:0]  hold_dest_q;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic                   flush, move;

    // A non-final beat waits in the hold stage until its successor shows up or the
    // idle timer expires, so the packet can be closed on the beat already seen.
    always_comb begin
        flush         = (hold_q == HELD) && !s_axis_tvalid && (tmo_q == TMO_MAX);
        move          = (hold_q == HELD) && reg_ready && (hold_last_q || s_axis_tvalid || flush);
        s_axis_tready = !rst && ((hold_q == EMPTY) || reg_ready);
        accept        = s_axis_tvalid && s_axis_tready;
        is_last       = (beat_cnt_q == LAST_CNT) || s_axis_tlast;

        reg_valid = move;
        reg_data  = hold_data_q;
        reg_keep  = hold_keep_q;
        reg_last  = hold_last_q || flush;
        reg_user  = hold_user_q;
        reg_dest  = hold_dest_q;

        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            beat_cnt_d = is_last ? '0 : beat_cnt_q + 1'b1;
        end else if (move && flush) begin
            beat_cnt_d = '0;
        end

        hold_d = hold_q;
        if (accept) begin
            hold_d = HELD;
        end else if (move) begin
            hold_d = EMPTY;
        end

        tmo_d = tmo_q;
        if (hold_q != HELD || s_axis_tvalid || move) begin
            tmo_d = '0;
        end else if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            hold_q      <= EMPTY;
            hold_data_q <= '0;
            hold_keep_q <= '0;
            hold_last_q <= 1'b0;
            hold_user_q <= '0;
            hold_dest_q <= '0;
            tmo_q       <= '0;
        end else begin
            hold_q <= hold_d;
            tmo_q  <= tmo_d;
            if (accept) begin
                hold_data_q <= s_axis_tdata;
                hold_keep_q <= s_axis_tkeep;
                hold_last_q <= is_last;
                hold_user_q <= s_axis_tuser;
                hold_dest_q <= s_axis_tdest;
            end
        end
    end
`else
    always_comb begin
        s_axis_tready = !rst && reg_ready;
        accept        = s_axis_tvalid && s_axis_tready;
        is_last       = (beat_cnt_q == LAST_CNT) || s_axis_tlast;

        reg_valid = accept;
        reg_data  = s_axis_tdata;
        reg_keep  = s_axis_tkeep;
        reg_last  = is_last;
        reg_user  = s_axis_tuser;
        reg_dest  = s_axis_tdest;

        beat_cnt_d = beat_cnt_q;
        if (accept) begin
            beat_cnt_d = is_last ? '0 : beat_cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge aclk) begin
        if (rst) begin
            beat_cnt_q   <= '0;
            packet_count <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                packet_count <= packet_count + 32'd1;
            end
        end
    end

    axis_packetizer_reg #(
        .DATA_W     (BUS_WIDTH * 8),
        .KEEP_W     (BUS_WIDTH),
        .USER_WIDTH (USER_WIDTH),
        .DEST_WIDTH (DEST_WIDTH)
    ) u_out_reg (
        .aclk      (aclk),
        .rst       (rst),
        .in_valid  (reg_valid),
        .in_ready  (reg_ready),
        .in_data   (reg_data),
        .in_keep   (reg_keep),
        .in_last   (reg_last),
        .in_user   (reg_user),
        .in_dest   (reg_dest),
        .out_valid (m_axis_tvalid),
        .out_ready (m_axis_tready),
        .out_data  (m_axis_tdata),
        .out_keep  (m_axis_tkeep),
        .out_last  (m_axis_tlast),
        .out_user  (m_axis_tuser),
        .out_dest  (m_axis_tdest)
    );

endmodule

// File: doc/axis_packetizer.md
AXIS_PACKETIZER -- requirements
Module: axis_packetizer

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 1, tdata width in bytes.
REQ-002 SHALL have parameter USER_WIDTH, default 1, tuser width in bits.
REQ-003 SHALL have parameter DEST_WIDTH, default 1, tdest width in bits.
REQ-004 SHALL have parameter PACKET_SIZE, default 16, beats per generated packet (legal range 1..65535).
REQ-005 SHALL have parameter TIMEOUT, default 64, idle cycles before a flush (legal range 2..65535; used only with AXIS_PACKETIZER_TIMEOUT_EN).
REQ-006 SHALL have port aclk, input, 1, the single clock for all logic.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have ports s_axis_tvalid/tready/tdata/tkeep/tlast/tuser/tdest: in/out/in/in/in/in/in, widths 1/1/BUS_WIDTH*8/BUS_WIDTH/1/USER_WIDTH/DEST_WIDTH, upstream stream fed by axis_xfifo m_axis.
REQ-009 SHALL have ports m_axis_tvalid/tready/tdata/tkeep/tlast/tuser/tdest: out/in/out/out/out/out/out, widths as REQ-008, packetized downstream stream.
REQ-010 SHALL have port packet_count, output, 32, count of tlast beats accepted downstream; wraps at 2^32.

Function
REQ-011 SHALL pass tdata/tkeep/tuser/tdest unmodified and in order; no beat dropped or duplicated.
REQ-012 SHALL keep beat_cnt 0..PACKET_SIZE-1 of beats moved to the output register since the last tlast.
REQ-013 SHALL drive m_axis_tlast=1 on a beat when beat_cnt==PACKET_SIZE-1 or s_axis_tlast=1 on it; beat_cnt then returns to 0.
REQ-014 SHALL hold m_axis_t* stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-015 SHALL load the output register when it is empty or m_axis_tready=1 in the same cycle (full throughput, one beat/cycle).
REQ-016 SHALL assert s_axis_tready only when the next stage has room; never depend combinationally on s_axis_tvalid.
REQ-017 SHALL have latency, macro off: accepted beat appears on m_axis the next cycle.
REQ-018 SHALL increment packet_count on each cycle with m_axis_tvalid & m_axis_tready & m_axis_tlast.
REQ-019 SHALL, with PACKET_SIZE=1, set tlast on every beat.

Reset
REQ-020 SHALL, while rst=1 at a rising aclk edge, clear m_axis_tvalid, s_axis_tready, m_axis_tlast, beat_cnt, timeout counter, hold valid, packet_count to 0; m_axis_tdata/tkeep/tuser/tdest to 0.
REQ-021 SHALL assert s_axis_tready=1 the first cycle after rst deasserts.
REQ-022 SHALL discard any held or output beat when rst asserts mid-packet; the first post-reset beat starts beat_cnt=0.

Configuration
REQ-023 SHALL, with macro AXIS_PACKETIZER_TIMEOUT_EN defined, add an internal hold register with states EMPTY and HELD ahead of the output register.
REQ-024 SHALL, with the macro, move a beat from HELD to output when its successor is accepted (tlast per REQ-013), or immediately when it is known final per REQ-013.
REQ-025 SHALL, with the macro, count consecutive HELD cycles with no s_axis_tvalid; at TIMEOUT move the held beat out with tlast=1 and reset beat_cnt; s_axis_tvalid=1 on the same cycle as TIMEOUT wins (no flush).
REQ-026 SHALL, with the macro, add exactly one cycle latency versus REQ-017 when not stalled.
REQ-027 SHALL, without the macro, contain no hold register or timeout counter; TIMEOUT ignored.

Structure
REQ-028 SHALL place the timeout-hold state encoding (EMPTY, HELD) and counter-width function clog2 in shared package axis_packetizer_pkg.
REQ-029 SHALL implement the output register as sub-module axis_packetizer_reg (one-entry AXIS register slice with tlast input).

Verification (BUS_WIDTH=1, PACKET_SIZE=4, TIMEOUT=8, m_axis_tready=1 unless stated)
REQ-030 SHALL check: bytes 0..11 continuous -> tlast on 3, 7, 11; packet_count=3.
REQ-031 SHALL check: s_axis_tlast=1 on byte 1 of 0..5 -> tlast on 1 and 5; beat_cnt restarts after 1.
REQ-032 SHALL check: random m_axis_tready (as $random%2) over 256 incrementing bytes -> output sequence 0..255 intact, outputs stable during stalls.
REQ-033 SHALL check, macro on: bytes 0,1 then 20 idle cycles -> byte 1 emitted with tlast=1 after 8 idle cycles; next byte 2 starts new packet.
REQ-034 SHALL check: rst asserted after byte 2 of a packet -> m_axis_tvalid=0 next cycle; next bytes 9..12 give tlast on 12.
REQ-035 SHALL check, macro off: bytes 0,1 then idle -> byte 1 emitted next cycle with tlast=0, no flush.
